// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer: owns the PC, fetches words from program
// memory over req/ack, and presents one instruction per EXEC cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | parked, waiting for run
// FETCH | imem_req high, address = pc, waiting for imem_ack
// EXEC  | one-cycle execute strobe, pc/flags/next state resolve at end
// HALT  | halt opcode executed; frozen until reset
module fetch_sequencer #(
    parameter int               PC_W     = 6,
    parameter int               OPR_W    = 6,
    parameter int               OPC_W    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter logic [OPC_W-1:0] HALT_OPC = '1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    output logic                   imem_req,
    output logic [PC_W-1:0]        imem_addr,
    input  logic                   imem_ack,
    input  logic [OPC_W+OPR_W-1:0] imem_data,
    output logic [OPC_W-1:0]       opcode,
    output logic [OPR_W-1:0]       operand,
    output logic                   instr_valid,
    input  logic                   jmp_sel,
    input  logic                   alu_cf,
    input  logic                   alu_zf,
    input  logic                   alu_sf,
    output logic                   cf,
    output logic                   zf,
    output logic                   sf,
    output logic [PC_W-1:0]        pc,
    output logic                   halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [OPC_W+OPR_W-1:0]   ir;
    logic [OPC_W-1:0]         ir_opc;
    logic [OPR_W-1:0]         ir_opr;
    logic                     alu_op;

    assign ir_opc = ir[OPC_W+OPR_W-1:OPR_W];
    assign ir_opr = ir[OPR_W-1:0];
    // Opcodes 00xx are ALU register ops; only those refresh the flags.
    assign alu_op = (ir_opc[OPC_W-1 -: 2] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (run) state_nxt = S_FETCH;
            S_FETCH: if (imem_ack) state_nxt = S_EXEC;
            S_EXEC: begin
                if (ir_opc == HALT_OPC) state_nxt = S_HALT;
                else if (run)           state_nxt = S_FETCH;
                else                    state_nxt = S_IDLE;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            S_FETCH: imem_req    = 1'b1;
            S_EXEC:  instr_valid = 1'b1;
            S_HALT:  halted      = 1'b1;
            default: ;
        endcase
    end

    // PC advances even on the halt instruction, so HALT shows the next address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            ir <= '0;
            cf <= 1'b0;
            zf <= 1'b0;
            sf <= 1'b0;
        end else begin
            if (state == S_FETCH && imem_ack) begin
                ir <= imem_data;
            end
            if (state == S_EXEC) begin
                pc <= jmp_sel ? PC_W'(ir_opr) : pc + PC_W'(1);
                if (alu_op) begin
                    cf <= alu_cf;
                    zf <= alu_zf;
                    sf <= alu_sf;
                end
            end
        end
    end

    assign imem_addr = pc;
    assign opcode    = ir_opc;
    assign operand   = ir_opr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed program walk plus randomized runs,
// checked each cycle against an instruction-level reference model.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       run = 1'b0;
    logic       imem_ack = 1'b0;
    logic [9:0] imem_data = '0;
    logic       jmp_sel = 1'b0;
    logic       alu_cf = 1'b0;
    logic       alu_zf = 1'b0;
    logic       alu_sf = 1'b0;
    logic       imem_req;
    logic [5:0] imem_addr;
    logic [3:0] opcode;
    logic [5:0] operand;
    logic       instr_valid;
    logic       cf, zf, sf;
    logic [5:0] pc;
    logic       halted;

    fetch_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .opcode     (opcode),
        .operand    (operand),
        .instr_valid(instr_valid),
        .jmp_sel    (jmp_sel),
        .alu_cf     (alu_cf),
        .alu_zf     (alu_zf),
        .alu_sf     (alu_sf),
        .cf         (cf),
        .zf         (zf),
        .sf         (sf),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model: architectural state at instruction granularity
    logic [9:0] mem [64];
    bit         jmp_at [64];
    logic [2:0] alu_at [64];
    int         m_pc;
    logic [2:0] m_flags;
    bit         m_halted;

    bit rand_jmp, rand_lat, rand_run, force_ack;
    int lat, wait_cnt, stop_at, exec_cnt, cyc, run_cyc;
    bit p_req, p_ack, p_valid, p_run, p_idle, p_halt_op;
    int valid_q[$];
    int fetch_q[$];

    task automatic tick();
        logic [9:0] w;
        bit         j;
        logic [2:0] a;
        bit         halt_op;
        p_run = run;
        p_ack = imem_ack;
        @(posedge clk);
        #1;
        cyc++;
        check("pc", 32'(pc), 32'(m_pc));
        check("flags", 32'({cf, zf, sf}), 32'(m_flags));
        check("valid_after_ack", 32'(instr_valid), 32'(p_req && p_ack));
        if (p_req && !p_ack) check("req_hold", 32'(imem_req), 32'd1);
        if (p_valid && p_halt_op) check("halt_entry", 32'(halted), 32'd1);
        if (p_valid && !p_halt_op) check("req_after_exec", 32'(imem_req), 32'(p_run));
        if (p_idle) check("idle_exit", 32'(imem_req), 32'(p_run));
        if (m_halted) begin
            check("halted", 32'(halted), 32'd1);
            check("halt_no_req", 32'(imem_req), 32'd0);
        end
        if (imem_req) begin
            check("imem_addr", 32'(imem_addr), 32'(m_pc));
            if (!p_req) fetch_q.push_back(int'(imem_addr));
        end
        halt_op = 1'b0;
        if (instr_valid) begin
            w = mem[m_pc];
            check("opcode", 32'(opcode), 32'(w[9:6]));
            check("operand", 32'(operand), 32'(w[5:0]));
            valid_q.push_back(cyc);
            exec_cnt++;
            j = rand_jmp ? bit'($urandom_range(0, 1)) : jmp_at[m_pc];
            a = rand_jmp ? 3'($urandom_range(0, 7)) : alu_at[m_pc];
            if (w[9:8] == 2'b00) m_flags = a;
            halt_op = (w[9:6] == 4'hF);
            if (halt_op) m_halted = 1'b1;
            m_pc = j ? int'(w[5:0]) : (m_pc + 1) % 64;
        end else begin
            j = bit'($urandom_range(0, 1));
            a = 3'($urandom_range(0, 7));
        end
        jmp_sel = j;
        {alu_cf, alu_zf, alu_sf} = a;
        if (rand_run) run = ($urandom_range(0, 7) != 0);
        if (stop_at > 0 && exec_cnt >= stop_at) run = 1'b0;
        if (imem_req) begin
            if (wait_cnt >= lat) begin
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr];
                wait_cnt  = 0;
                if (rand_lat) lat = $urandom_range(0, 3);
            end else begin
                imem_ack  = 1'b0;
                imem_data = 10'($urandom);
                wait_cnt++;
            end
        end else begin
            imem_ack  = force_ack ? 1'b1 : ($urandom_range(0, 3) == 0);
            imem_data = 10'($urandom);
            wait_cnt  = 0;
        end
        p_req     = imem_req;
        p_valid   = instr_valid;
        p_idle    = !imem_req && !instr_valid && !halted;
        p_halt_op = halt_op;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        run      = 1'b0;
        imem_ack = force_ack;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", 32'({opcode, operand}), 32'd0);
        check("rst_flags", 32'({cf, zf, sf}), 32'd0);
        m_pc = 0; m_flags = '0; m_halted = 1'b0;
        wait_cnt = 0; exec_cnt = 0; stop_at = 0;
        valid_q.delete();
        fetch_q.delete();
        p_req = 1'b0; p_valid = 1'b0; p_idle = 1'b1; p_halt_op = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_addr[5];
        rand_jmp = 0; rand_lat = 0; rand_run = 0; force_ack = 0;
        lat = 0; cyc = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 10'h200; jmp_at[i] = 1'b0; alu_at[i] = 3'b000;
        end
        #1;
        do_reset();

        // zero-wait sequential fetch of three words
        mem[0] = 10'h005; mem[1] = 10'h041; mem[2] = 10'h082;
        tick();
        run = 1'b1;
        run_cyc = cyc;
        stop_at = 3;
        for (int k = 0; k < 30 && exec_cnt < 3; k++) tick();
        check("seq_exec_count", 32'(exec_cnt), 32'd3);
        tick();
        tick();
        check("seq_pc_end", 32'(pc), 32'd3);
        check("seq_idle_req", 32'(imem_req), 32'd0);
        if (valid_q.size() == 3 && fetch_q.size() == 3) begin
            check("first_valid_latency", 32'(valid_q[0] - run_cyc), 32'd2);
            check("valid_spacing_1", 32'(valid_q[1] - valid_q[0]), 32'd2);
            check("valid_spacing_2", 32'(valid_q[2] - valid_q[1]), 32'd2);
            for (int i = 0; i < 3; i++) check("seq_addr", 32'(fetch_q[i]), 32'(i));
        end else begin
            check("seq_valid_count", 32'(valid_q.size()), 32'd3);
            check("seq_fetch_count", 32'(fetch_q.size()), 32'd3);
        end

        // slow memory: jumps, pc wrap, flag hold, halt
        stop_at = 0; lat = 3; wait_cnt = 0;
        mem[3]  = 10'h12A; jmp_at[3]  = 1'b1;
        mem[42] = 10'h03F; jmp_at[42] = 1'b1; alu_at[42] = 3'b101;
        mem[63] = 10'h200; jmp_at[63] = 1'b0; alu_at[63] = 3'b000;
        mem[0]  = 10'h104; jmp_at[0]  = 1'b1;
        mem[4]  = 10'h3C0; jmp_at[4]  = 1'b0;
        valid_q.delete();
        fetch_q.delete();
        run = 1'b1;
        for (int k = 0; k < 200 && !halted; k++) tick();
        check("halt_reached", 32'(halted), 32'd1);
        check("halt_pc", 32'(pc), 32'd5);
        check("flags_held", 32'({cf, zf, sf}), 32'b101);
        exp_addr = '{3, 42, 63, 0, 4};
        if (fetch_q.size() == 5) begin
            for (int i = 0; i < 5; i++) check("jump_addr", 32'(fetch_q[i]), 32'(exp_addr[i]));
        end else begin
            check("jump_fetch_count", 32'(fetch_q.size()), 32'd5);
        end
        repeat (5) tick();
        check("halt_frozen_pc", 32'(pc), 32'd5);
        do_reset();
        tick();
        check("post_halt_pc", 32'(pc), 32'd0);
        check("post_halt_halted", 32'(halted), 32'd0);

        // async reset in the middle of a fetch, then a late ack
        mem[0] = 10'h005;
        run = 1'b1; lat = 5; wait_cnt = 0;
        for (int k = 0; k < 5 && !imem_req; k++) tick();
        tick();
        check("req_before_rst", 32'(imem_req), 32'd1);
        force_ack = 1'b1;
        do_reset();
        repeat (4) tick();
        force_ack = 1'b0;
        check("late_ack_req", 32'(imem_req), 32'd0);
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        check("late_ack_pc", 32'(pc), 32'd0);

        // randomized programs, latencies, run and jump patterns
        rand_jmp = 1; rand_lat = 1; rand_run = 1;
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int i = 0; i < 64; i++) begin
                mem[i] = 10'($urandom);
                if (mem[i][9:6] == 4'hF && $urandom_range(0, 3) != 0) mem[i][9:6] = 4'h0;
            end
            lat = $urandom_range(0, 3);
            run = 1'b1;
            repeat (400) tick();
        end
        rand_jmp = 0; rand_lat = 0; rand_run = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-issue side of the 6-bit CPU opcode interface: owns the program counter and fetches 10-bit instruction words from program memory over a req/ack handshake.
- Presents OPCODE/OPERAND plus registered CF/ZF/SF to the control unit, and consumes the control unit's JMP_SEL to pick the next PC.
- Sits between program memory and the decode/datapath; one instruction issued per fetch/exec round.

Parameters:
- PC_W, 6, program counter and memory address width
- OPR_W, 6, operand/immediate width (= datapath width)
- OPC_W, 4, opcode width
- RESET_PC, 0, PC value after reset
- HALT_OPC, 4'b1111, opcode that stops the sequencer

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- RUN  in  1  level enable; sequencer fetches while high
- IMEM_REQ  out  1  fetch request to program memory
- IMEM_ADDR  out  PC_W  fetch address, equals PC
- IMEM_ACK  in  1  memory has valid IMEM_DATA this cycle
- IMEM_DATA  in  OPC_W+OPR_W  instruction word {opcode[9:6], operand[5:0]}
- OPCODE  out  OPC_W  current instruction opcode to control unit
- OPERAND  out  OPR_W  immediate / jump target
- INSTR_VALID  out  1  one-cycle execute strobe
- JMP_SEL  in  1  jump-taken from control unit (combinational on OPCODE)
- ALU_CF, ALU_ZF, ALU_SF  in  1 each  raw ALU flags for current instruction
- CF, ZF, SF  out  1 each  registered flags to control unit
- PC  out  PC_W  current program counter
- HALTED  out  1  high in HALT state

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE, PC=RESET_PC, IR=0 (OPCODE=0, OPERAND=0), CF=ZF=SF=0, IMEM_REQ=0, INSTR_VALID=0, HALTED=0. Reset mid-fetch drops IMEM_REQ immediately; the pending ACK is ignored after release.
- States: IDLE, FETCH, EXEC, HALT; all outputs registered or decoded from registered state only.
- IDLE: RUN=1 -> FETCH next cycle; otherwise stay.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC held stable until ACK. On IMEM_ACK=1: IR<=IMEM_DATA, -> EXEC. ACK in the first FETCH cycle is legal (zero-wait memory). RUN falling during FETCH does not abort; the fetch completes.
- IMEM_ACK outside FETCH is ignored.
- EXEC (exactly 1 cycle): INSTR_VALID=1; OPCODE/OPERAND driven from IR, stable for the whole cycle.
- At EXEC end: PC <= JMP_SEL ? OPERAND : PC+1, modulo 2^PC_W (63+1 wraps to 0).
- At EXEC end, flags update: if OPCODE[3:2]==2'b00 (ALU register op), CF/ZF/SF <= ALU_CF/ALU_ZF/ALU_SF; otherwise flags hold.
- At EXEC end, next state:
  - OPCODE==HALT_OPC -> HALT; PC still advances per the rule above.
  - else RUN=1 -> FETCH.
  - else -> IDLE.
- HALT: HALTED=1, IMEM_REQ=0, INSTR_VALID=0; PC, IR and flags frozen; RUN ignored. Exit only via reset.
- Throughput: 2 cycles per instruction with zero-wait memory; first INSTR_VALID occurs 2 cycles after RUN is sampled high in IDLE.
- Flags seen by the control unit during an instruction are those from the most recent completed ALU instruction.

Test Plan:
- Reset then RUN=1, zero-wait memory, words 0x005,0x041,0x082 at 0,1,2 -> IMEM_ADDR 0,1,2; INSTR_VALID every 2nd cycle; OPCODE 0,1,2 with OPERAND 5,1,2; PC ends at 3.
- EXEC with OPERAND=0x2A and JMP_SEL forced 1 -> next IMEM_ADDR=42. Same with JMP_SEL=0 at PC=63 -> next address 0.
- ACK delayed 3 cycles; IMEM_DATA toggles before ACK -> IMEM_REQ and IMEM_ADDR stable throughout; IR captures only the word presented with ACK.
- ALU op (opcode 0000) with ALU_CF=1, ALU_ZF=0, ALU_SF=1, then opcode 1000 with ALU flags all 0 -> CF/SF stay 1 and ZF stays 0 after the second instruction.
- Word 0x3C0 (opcode 1111) at PC=4 -> HALTED=1, PC=5, no further IMEM_REQ while RUN stays high; RST_N pulse -> IDLE with PC=0.
- RST_N asserted during FETCH with IMEM_REQ=1 -> IMEM_REQ=0 in the same cycle with no clock edge; late ACK after release is ignored; state IDLE, PC=0.
